ofs_plat_hssi_tx_pkt_buffer: RTL and testbench
==============================================

# ofs_plat_hssi_tx_pkt_buffer

AFU-side store-and-forward transmit buffer for one HSSI channel, the producer end of the Tx AXI-S stream that the FIM Ethernet MAC consumes. It accepts packets from the AFU traffic manager, holds each packet until its last word arrives, then replays it to the MAC with no mid-packet bubbles, because the MAC must never see a tvalid gap inside a frame. Packets longer than a configured maximum are truncated and the remainder is discarded.

## Interface
Parameters:
- DATA_WIDTH, 64: tdata width in bits; tkeep is DATA_WIDTH/8 bits.
- DEPTH, 512: buffer depth in words; power of 2.
- MAX_PKT_WORDS, 256: longest accepted packet in words; 2 ≤ MAX_PKT_WORDS ≤ DEPTH.

Ports:
- clk  in  1  channel clock, shared by all streams.
- reset_n  in  1  asynchronous, active-low reset.
- s_tvalid / s_tready  in / out  1 / 1  AFU-side ingress handshake.
- s_tdata / s_tkeep / s_tlast  in  DATA_WIDTH / DATA_WIDTH/8 / 1  ingress payload.
- m_tvalid / m_tready  out / in  1 / 1  MAC-side egress handshake.
- m_tdata / m_tkeep / m_tlast  out  DATA_WIDTH / DATA_WIDTH/8 / 1  egress payload.
- pkt_count  out  $clog2(DEPTH)+1  number of complete packets held.
- trunc_err  out  1  one-cycle pulse when a packet is truncated.

## Operation
- Word storage is a circular RAM with write and read pointers of width $clog2(DEPTH)+1, using the extra bit for wrap. Full means the pointers are equal except for the MSB. Empty means the pointers are equal.
- Ingress FSM:
  - ACCEPT: s_tready = !full. An accepted word is written with its tdata, tkeep, and tlast.
  - A word counter wc counts words of the current packet. It clears on tlast and on truncation.
  - Truncation: if wc == MAX_PKT_WORDS-1 and s_tlast == 0, the word is written with tlast forced to 1, trunc_err pulses, and the FSM moves to DISCARD.
  - DISCARD: s_tready = 1. Words are dropped, nothing is written. The FSM returns to ACCEPT the cycle after an accepted s_tlast.
- pkt_count:
  - +1 when a word with stored tlast = 1 is written.
  - −1 when an m_tlast handshake occurs.
  - Both events in the same cycle leave it unchanged.
- Egress: m_tvalid is asserted only while pkt_count != 0 or the head packet is partially sent. Because storage is FIFO-ordered, the head packet is always complete in the buffer, so the egress side never underflows mid-packet.
- Deadlock freedom: MAX_PKT_WORDS ≤ DEPTH, so a single partial packet can never fill the buffer unless complete packets precede it and can drain.

## Timing
- Reset values: s_tready=0, m_tvalid=0, m_tdata=0, m_tkeep=0, m_tlast=0, pkt_count=0, trunc_err=0. Pointers clear and the FSM enters ACCEPT.
- s_tready rises in the first clk edge after reset_n deasserts.
- Latency: the first word of a packet appears on m_* no earlier than 2 cycles after its tlast handshake (1 cycle count update, 1 cycle RAM read into the output register).
- Throughput: 1 word/cycle per side, with simultaneous read and write allowed. The output register is prefetched, so back-to-back packets have no idle cycle.
- m_* holds stable while m_tvalid && !m_tready.
- Full and a same-cycle read: s_tready is computed from the registered full flag and does not use the same-cycle read. This costs one cycle of ingress stall and is accepted.
- Reset asserted mid-packet: all buffered data is lost. m_tvalid drops asynchronously; the MAC shares this reset domain.
- trunc_err is asserted in the cycle following the truncating handshake.

## Configuration
- OFS_PLAT_HSSI_TX_PKT_BUFFER_STATS_EN defined: adds two outputs.
  - stat_tx_pkts (32b): increments on each m_tlast handshake.
  - stat_trunc_pkts (32b): increments on each truncation.
  - Both saturate at all-ones and reset to 0.
- Not defined: the ports and counters do not exist. All other behaviour is identical.

## Structure
- Shared package ofs_plat_hssi_tx_pkg holds:
  - t_tx_word struct {tdata, tkeep, tlast}, parameterised via localparam widths.
  - t_ingress_state enum {ACCEPT, DISCARD}.
  - The stats counter width constant.
- Sub-module ofs_plat_hssi_tx_pkt_ram: simple dual-port RAM holding t_tx_word, 1-cycle registered read, no reset on contents.

## Test plan
- Single 4-word packet, m_tready=1: m_tvalid rises 2 cycles after s_tlast. Four contiguous beats, tlast on beat 4, pkt_count 1→0.
- AFU stalls 10 cycles mid-packet (s_tvalid=0): no m_tvalid until tlast is accepted, then all words emitted without gaps.
- 300-word packet with MAX_PKT_WORDS=256:
  - 256 words emitted, with word 256 carrying m_tlast=1.
  - trunc_err pulses once.
  - s_tready stays 1 through the remaining 44 words.
  - The next packet passes intact.
- Fill with DEPTH=512 using two 256-word packets while m_tready=0: s_tready=0 at 512 words and pkt_count=2. Releasing m_tready drains both packets in order.
- Simultaneous events: a tlast write and an m_tlast read in the same cycle leave pkt_count unchanged. Pointer wrap past 512 keeps data intact.
- Assert reset_n=0 mid-egress: all outputs drop to reset values. A fresh packet after release passes correctly. With STATS_EN, the counters restart at 0.

Source files
------------

// File: rtl/ofs_plat_hssi_tx_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : ofs_plat_hssi_tx_pkg
// Purpose : Shared types and constants for the HSSI Tx packet buffer.
//           t_tx_word is the default storage word layout (64-bit tdata).
//           t_ingress_state is the ingress FSM encoding.
//           c_stats_width is the width of the optional statistics counters.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
package ofs_plat_hssi_tx_pkg;

  localparam int c_tx_data_width = 64;
  localparam int c_tx_keep_width = c_tx_data_width / 8;
  localparam int c_stats_width   = 32;

  typedef struct packed {
    logic [c_tx_data_width-1:0] tdata;
    logic [c_tx_keep_width-1:0] tkeep;
    logic                       tlast;
  } t_tx_word;

  typedef enum logic [0:0] {
    ACCEPT  = 1'b0,
    DISCARD = 1'b1
  } t_ingress_state;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [c_stats_width-1:0] sat_inc(input logic [c_stats_width-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ofs_plat_hssi_tx_pkt_ram.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : ofs_plat_hssi_tx_pkt_ram
// Purpose : Simple dual-port word store for the Tx packet buffer.
//           One write port, one read port with a single registered read stage.
//           Array contents are not reset; only the read register is, so the
//           egress payload comes up as zero.
// Ports   : clk, reset_n        clock / async active-low reset
//           wr_en/wr_addr/wr_data write port
//           rd_en/rd_addr        read request, data valid on rd_data next cycle
//           rd_data              registered read data (held when rd_en=0)
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
module ofs_plat_hssi_tx_pkt_ram
  import ofs_plat_hssi_tx_pkg::*;
#(
  parameter int  DEPTH  = 512,
  parameter type T_WORD = t_tx_word
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  T_WORD                    wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output T_WORD                    rd_data
);

  T_WORD r_mem [DEPTH];
  T_WORD r_rdata;

  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   r_rdata <= '0;
    else if (rd_en) r_rdata <= r_mem[rd_addr];
  end

  assign rd_data = r_rdata;

endmodule
`default_nettype wire

// File: rtl/ofs_plat_hssi_tx_pkt_buffer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : ofs_plat_hssi_tx_pkt_buffer
// Purpose : Store-and-forward Tx buffer between the AFU and the Ethernet MAC.
//           A packet is released to egress only once its last word is stored,
//           so m_tvalid never gaps inside a frame. Packets longer than
//           MAX_PKT_WORDS are cut (last kept word gets tlast) and the rest of
//           the packet is dropped.
// Ports   : clk, reset_n                   clock / async active-low reset
//           s_tvalid/s_tready/s_t*          ingress AXI-S from the AFU
//           m_tvalid/m_tready/m_t*          egress AXI-S to the MAC
//           pkt_count                       complete packets held
//           trunc_err                       1-cycle pulse after a truncation
// Macro   : OFS_PLAT_HSSI_TX_PKT_BUFFER_STATS_EN adds saturating counters
//           stat_tx_pkts and stat_trunc_pkts.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
module ofs_plat_hssi_tx_pkt_buffer
  import ofs_plat_hssi_tx_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int DEPTH         = 512,
  parameter int MAX_PKT_WORDS = 256
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_tkeep,
  input  logic                    s_tlast,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [DATA_WIDTH-1:0]   m_tdata,
  output logic [DATA_WIDTH/8-1:0] m_tkeep,
  output logic                    m_tlast,
  output logic [$clog2(DEPTH):0]  pkt_count,
  output logic                    trunc_err
`ifdef OFS_PLAT_HSSI_TX_PKT_BUFFER_STATS_EN
  ,
  output logic [c_stats_width-1:0] stat_tx_pkts,
  output logic [c_stats_width-1:0] stat_trunc_pkts
`endif
);

  localparam int c_aw  = $clog2(DEPTH);
  localparam int c_pw  = c_aw + 1;
  localparam int c_wcw = $clog2(MAX_PKT_WORDS) + 1;
  localparam logic [c_wcw-1:0] c_wc_last = c_wcw'(MAX_PKT_WORDS - 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tlast;
  } t_word;

  t_ingress_state r_state, w_state_nxt;
  logic           r_in_en;          // holds s_tready low until the first edge after reset
  logic [c_pw-1:0] r_wr_ptr;        // next write slot
  logic [c_pw-1:0] r_cm_ptr;        // one past the last stored tlast word
  logic [c_pw-1:0] r_rd_ptr;        // next word to fetch into the output register
  logic [c_pw-1:0] r_fr_ptr;        // slots freed by egress handshakes
  logic [c_wcw-1:0] r_wc;
  logic [c_pw-1:0] r_pkt_count;
  logic            r_trunc_err;
  logic            r_m_valid;
  logic            w_s_tready, w_s_hs, w_wr_en, w_trunc;
  logic            w_full, w_avail, w_rd_en, w_m_hs;
  t_word           w_wr_word, w_rd_word;

  // Full is measured against freed slots rather than fetched ones, so the
  // word parked in the output register still counts as occupying the buffer.
  assign w_full  = (r_wr_ptr == {~r_fr_ptr[c_aw], r_fr_ptr[c_aw-1:0]});
  // Only words of complete packets are eligible for fetch.
  assign w_avail = (r_rd_ptr != r_cm_ptr);
  assign w_m_hs  = r_m_valid & m_tready;
  assign w_rd_en = w_avail & (~r_m_valid | m_tready);

  assign w_s_hs  = s_tvalid & w_s_tready;
  assign w_trunc = w_wr_en & (r_wc == c_wc_last) & ~s_tlast;

  assign w_wr_word.tdata = s_tdata;
  assign w_wr_word.tkeep = s_tkeep;
  assign w_wr_word.tlast = s_tlast | w_trunc;

  // Ingress FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ACCEPT;
    else          r_state <= w_state_nxt;
  end

  // Ingress FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACCEPT:  if (w_trunc) w_state_nxt = DISCARD;
      DISCARD: if (w_s_hs && s_tlast) w_state_nxt = ACCEPT;
      default: w_state_nxt = ACCEPT;
    endcase
  end

  // Ingress FSM: outputs
  always_comb begin
    w_s_tready = 1'b0;
    w_wr_en    = 1'b0;
    case (r_state)
      ACCEPT: begin
        w_s_tready = r_in_en & ~w_full;
        w_wr_en    = s_tvalid & w_s_tready;
      end
      DISCARD: w_s_tready = r_in_en;
      default: w_s_tready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_in_en     <= 1'b0;
      r_wr_ptr    <= '0;
      r_cm_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fr_ptr    <= '0;
      r_wc        <= '0;
      r_pkt_count <= '0;
      r_trunc_err <= 1'b0;
      r_m_valid   <= 1'b0;
    end else begin
      r_in_en     <= 1'b1;
      r_trunc_err <= w_trunc;
      r_m_valid   <= w_rd_en | (r_m_valid & ~m_tready);
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_wc     <= w_wr_word.tlast ? '0 : r_wc + 1'b1;
        if (w_wr_word.tlast) r_cm_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_m_hs)  r_fr_ptr <= r_fr_ptr + 1'b1;
      case ({w_wr_en & w_wr_word.tlast, w_m_hs & w_rd_word.tlast})
        2'b10:   r_pkt_count <= r_pkt_count + 1'b1;
        2'b01:   r_pkt_count <= r_pkt_count - 1'b1;
        default: r_pkt_count <= r_pkt_count;
      endcase
    end
  end

  // The RAM read register doubles as the egress output register.
  ofs_plat_hssi_tx_pkt_ram #(
    .DEPTH  (DEPTH),
    .T_WORD (t_word)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (w_wr_en),
    .wr_addr (r_wr_ptr[c_aw-1:0]),
    .wr_data (w_wr_word),
    .rd_en   (w_rd_en),
    .rd_addr (r_rd_ptr[c_aw-1:0]),
    .rd_data (w_rd_word)
  );

  assign s_tready  = w_s_tready;
  assign m_tvalid  = r_m_valid;
  assign m_tdata   = w_rd_word.tdata;
  assign m_tkeep   = w_rd_word.tkeep;
  assign m_tlast   = w_rd_word.tlast;
  assign pkt_count = r_pkt_count;
  assign trunc_err = r_trunc_err;

`ifdef OFS_PLAT_HSSI_TX_PKT_BUFFER_STATS_EN
  logic [c_stats_width-1:0] r_stat_tx, r_stat_trunc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stat_tx    <= '0;
      r_stat_trunc <= '0;
    end else begin
      if (w_m_hs && w_rd_word.tlast) r_stat_tx    <= sat_inc(r_stat_tx);
      if (w_trunc)                   r_stat_trunc <= sat_inc(r_stat_trunc);
    end
  end

  assign stat_tx_pkts    = r_stat_tx;
  assign stat_trunc_pkts = r_stat_trunc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ofs_plat_hssi_tx_pkt_buffer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_ofs_plat_hssi_tx_pkt_buffer
// Purpose : Self-checking bench for ofs_plat_hssi_tx_pkt_buffer.
//           Ingress words are pushed to a scoreboard (with truncation applied
//           by a small reference model) and popped on each egress handshake.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
module tb_ofs_plat_hssi_tx_pkt_buffer;

  localparam int DW    = 64;
  localparam int KW    = DW / 8;
  localparam int DEPTH = 512;
  localparam int MAXW  = 256;
  localparam int PW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [DW-1:0] s_tdata = '0;
  logic [KW-1:0] s_tkeep = '0;
  logic          s_tlast = 1'b0;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tlast;
  logic [PW-1:0] pkt_count;
  logic          trunc_err;
`ifdef OFS_PLAT_HSSI_TX_PKT_BUFFER_STATS_EN
  logic [31:0]   stat_tx_pkts, stat_trunc_pkts;
`endif

  always #5 clk = ~clk;

  ofs_plat_hssi_tx_pkt_buffer #(
    .DATA_WIDTH    (DW),
    .DEPTH         (DEPTH),
    .MAX_PKT_WORDS (MAXW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .s_tdata   (s_tdata),
    .s_tkeep   (s_tkeep),
    .s_tlast   (s_tlast),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tdata   (m_tdata),
    .m_tkeep   (m_tkeep),
    .m_tlast   (m_tlast),
    .pkt_count (pkt_count),
    .trunc_err (trunc_err)
`ifdef OFS_PLAT_HSSI_TX_PKT_BUFFER_STATS_EN
    ,
    .stat_tx_pkts    (stat_tx_pkts),
    .stat_trunc_pkts (stat_trunc_pkts)
`endif
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } exp_t;

  typedef struct {
    int len;
    int stall_at;
    int stall_len;
    int bp;
    int exp_len;
    int exp_trunc;
  } vec_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // reference ingress model state
  bit m_discard = 1'b0;
  int m_wc = 0;
  int exp_trunc = 0;
  int disc_stalls = 0;

  // egress monitor state
  int   pkts_out = 0;
  int   words_in_pkt = 0;
  int   last_pkt_len = 0;
  int   trunc_seen = 0;
  bit   in_pkt = 1'b0;
  bit   prev_stall = 1'b0;
  exp_t prev_word = '0;

  // 0: m_tready low, 1: high, 2: random backpressure. Applied 2ns after each edge.
  int ready_mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       m_tready = 1'b0;
      1:       m_tready = 1'b1;
      default: m_tready = ($urandom_range(0, 3) != 0);
    endcase
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      words_in_pkt = 0;
      in_pkt       = 1'b0;
      prev_stall   = 1'b0;
    end else begin
      if (prev_stall)
        chk("hold_stable", {63'd0, (m_tvalid && ({m_tdata, m_tkeep, m_tlast} == prev_word))}, 64'd1);
      if (in_pkt) chk("no_gap", {63'd0, m_tvalid}, 64'd1);
      if (m_tvalid && m_tready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("beat_data", m_tdata, e.d);
          chk("beat_keep", {56'd0, m_tkeep}, {56'd0, e.k});
          chk("beat_last", {63'd0, m_tlast}, {63'd0, e.l});
        end
        words_in_pkt++;
        if (m_tlast) begin
          last_pkt_len = words_in_pkt;
          words_in_pkt = 0;
          pkts_out++;
          in_pkt = 1'b0;
        end else begin
          in_pkt = 1'b1;
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_word  = {m_tdata, m_tkeep, m_tlast};
      if (trunc_err) trunc_seen++;
    end
  end

  task automatic model_accept(input logic [DW-1:0] d, input logic [KW-1:0] k, input bit l);
    if (!m_discard) begin
      if (m_wc == MAXW - 1 && !l) begin
        sb.push_back({d, k, 1'b1});
        m_discard = 1'b1;
        m_wc = 0;
        exp_trunc++;
      end else begin
        sb.push_back({d, k, l});
        m_wc = l ? 0 : m_wc + 1;
      end
    end else if (l) begin
      m_discard = 1'b0;
    end
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic drive_cycle(input bit v, input logic [DW-1:0] d, input logic [KW-1:0] k,
                             input bit l, output bit hs);
    s_tvalid = v;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    @(negedge clk);
    hs = v && s_tready;
    if (m_discard && v && !s_tready) disc_stalls++;
    if (hs) model_accept(d, k, l);
    @(posedge clk);
    #1;
  endtask

  task automatic send_packet(input int len, input int stall_at, input int stall_len);
    bit            hs;
    int            tries;
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    for (int i = 0; i < len; i++) begin
      if (stall_len > 0 && i == stall_at) begin
        s_tvalid = 1'b0;
        for (int j = 0; j < stall_len; j++) begin
          @(negedge clk);
          chk("stall_no_valid", {63'd0, m_tvalid}, 64'd0);
          @(posedge clk);
          #1;
        end
      end
      d = {$urandom(), $urandom()};
      k = KW'($urandom());
      tries = 0;
      hs = 1'b0;
      while (!hs && tries < 2000) begin
        drive_cycle(1'b1, d, k, (i == len - 1), hs);
        tries++;
      end
      if (!hs) begin
        chk("ingress_timeout", 64'd0, 64'd1);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        return;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_pkts(input int target);
    int n;
    n = 0;
    while (pkts_out < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_count", 64'(pkts_out), 64'(target));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete (errors=%0d)", errors);
    $fatal(1);
  end

  vec_t vecs[7];
  int   p0, t0;
  bit   hs;

  initial begin
    vecs[0] = '{len:1,   stall_at:0, stall_len:0,  bp:0, exp_len:1,   exp_trunc:0};
    vecs[1] = '{len:3,   stall_at:0, stall_len:0,  bp:1, exp_len:3,   exp_trunc:0};
    vecs[2] = '{len:10,  stall_at:5, stall_len:10, bp:0, exp_len:10,  exp_trunc:0};
    vecs[3] = '{len:256, stall_at:0, stall_len:0,  bp:0, exp_len:256, exp_trunc:0};
    vecs[4] = '{len:300, stall_at:0, stall_len:0,  bp:0, exp_len:256, exp_trunc:1};
    vecs[5] = '{len:257, stall_at:0, stall_len:0,  bp:1, exp_len:256, exp_trunc:1};
    vecs[6] = '{len:6,   stall_at:0, stall_len:0,  bp:1, exp_len:6,   exp_trunc:0};

    // ---- reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_tready",  {63'd0, s_tready}, 64'd0);
    chk("rst_m_tvalid",  {63'd0, m_tvalid}, 64'd0);
    chk("rst_m_tdata",   m_tdata, 64'd0);
    chk("rst_m_tkeep",   {56'd0, m_tkeep}, 64'd0);
    chk("rst_m_tlast",   {63'd0, m_tlast}, 64'd0);
    chk("rst_pkt_count", {54'd0, pkt_count}, 64'd0);
    chk("rst_trunc_err", {63'd0, trunc_err}, 64'd0);
    reset_n = 1'b1;
    #1;
    chk("rel_s_tready_before_edge", {63'd0, s_tready}, 64'd0);
    @(posedge clk);
    #1;
    chk("rel_s_tready_after_edge", {63'd0, s_tready}, 64'd1);
`ifdef OFS_PLAT_HSSI_TX_PKT_BUFFER_STATS_EN
    chk("rst_stat_tx",    64'(stat_tx_pkts), 64'd0);
    chk("rst_stat_trunc", 64'(stat_trunc_pkts), 64'd0);
`endif

    // ---- single 4-word packet: latency and count
    ready_mode = 1;
    send_packet(4, 0, 0);
    @(negedge clk);
    chk("lat_cycle1_valid", {63'd0, m_tvalid}, 64'd0);
    chk("lat_cycle1_count", {54'd0, pkt_count}, 64'd1);
    @(negedge clk);
    chk("lat_cycle2_valid", {63'd0, m_tvalid}, 64'd1);
    @(posedge clk);
    #1;
    wait_pkts(1);
    chk("p4_len",   64'(last_pkt_len), 64'd4);
    chk("p4_count", {54'd0, pkt_count}, 64'd0);

    // ---- table-driven packets
    for (int i = 0; i < 7; i++) begin
      p0 = pkts_out;
      t0 = trunc_seen;
      disc_stalls = 0;
      ready_mode = vecs[i].bp ? 2 : 1;
      send_packet(vecs[i].len, vecs[i].stall_at, vecs[i].stall_len);
      wait_pkts(p0 + 1);
      repeat (2) @(posedge clk);
      #1;
      chk("vec_pkt_len",      64'(last_pkt_len), 64'(vecs[i].exp_len));
      chk("vec_trunc_pulses", 64'(trunc_seen - t0), 64'(vecs[i].exp_trunc));
      chk("vec_discard_stall", 64'(disc_stalls), 64'd0);
      chk("vec_sb_empty",     64'(sb.size()), 64'd0);
      chk("vec_pkt_count",    {54'd0, pkt_count}, 64'd0);
    end

    // ---- fill with two 256-word packets while egress is stalled
    ready_mode = 0;
    @(posedge clk);
    #1;
    p0 = pkts_out;
    send_packet(256, 0, 0);
    send_packet(256, 0, 0);
    s_tvalid = 1'b1;
    s_tlast  = 1'b0;
    @(negedge clk);
    chk("full_s_tready",  {63'd0, s_tready}, 64'd0);
    chk("full_pkt_count", {54'd0, pkt_count}, 64'd2);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    ready_mode = 1;
    wait_pkts(p0 + 2);
    chk("fill_sb_empty", 64'(sb.size()), 64'd0);
    chk("fill_last_len", 64'(last_pkt_len), 64'd256);

    // ---- tlast write and m_tlast read on the same edge
    ready_mode = 0;
    @(posedge clk);
    #1;
    p0 = pkts_out;
    send_packet(2, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    ready_mode = 1;
    drive_cycle(1'b1, 64'h0B0B_0000_0000_0000, 8'hFF, 1'b0, hs);
    chk("same_b0_hs", {63'd0, hs}, 64'd1);
    chk("same_pre_count", {54'd0, pkt_count}, 64'd1);
    chk("same_pre_tail",  {62'd0, m_tvalid, m_tlast}, 64'd3);
    drive_cycle(1'b1, 64'h0B0B_0000_0000_0001, 8'h0F, 1'b1, hs);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    chk("same_b1_hs", {63'd0, hs}, 64'd1);
    chk("same_post_count", {54'd0, pkt_count}, 64'd1);
    wait_pkts(p0 + 2);
    chk("same_final_count", {54'd0, pkt_count}, 64'd0);

`ifdef OFS_PLAT_HSSI_TX_PKT_BUFFER_STATS_EN
    chk("stat_tx_total",    64'(stat_tx_pkts), 64'(pkts_out));
    chk("stat_trunc_total", 64'(stat_trunc_pkts), 64'(exp_trunc));
`endif

    // ---- reset in the middle of egress
    ready_mode = 0;
    @(posedge clk);
    #1;
    send_packet(8, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    ready_mode = 1;
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_m_tvalid",  {63'd0, m_tvalid}, 64'd0);
    chk("mid_rst_m_tdata",   m_tdata, 64'd0);
    chk("mid_rst_m_tlast",   {63'd0, m_tlast}, 64'd0);
    chk("mid_rst_pkt_count", {54'd0, pkt_count}, 64'd0);
    chk("mid_rst_s_tready",  {63'd0, s_tready}, 64'd0);
    sb.delete();
    m_discard = 1'b0;
    m_wc = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_s_tready", {63'd0, s_tready}, 64'd1);
`ifdef OFS_PLAT_HSSI_TX_PKT_BUFFER_STATS_EN
    chk("post_rst_stat_tx",    64'(stat_tx_pkts), 64'd0);
    chk("post_rst_stat_trunc", 64'(stat_trunc_pkts), 64'd0);
`endif
    p0 = pkts_out;
    send_packet(5, 0, 0);
    wait_pkts(p0 + 1);
    chk("post_rst_len",   64'(last_pkt_len), 64'd5);
    chk("post_rst_count", {54'd0, pkt_count}, 64'd0);
`ifdef OFS_PLAT_HSSI_TX_PKT_BUFFER_STATS_EN
    chk("post_rst_stat_tx1", 64'(stat_tx_pkts), 64'd1);
`endif

    chk("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
